// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types for the 5-stage pipeline hazard controller: FSM states,
// forwarding-mux selects and the all-zero control word loaded as a bubble.
package pipeline_hazard_controller_pkg;

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } hzState_t;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic       regWrite;
        logic       memToReg;
        logic       memRead;
        logic       memWrite;
        logic       branch;
        logic       aluSrc;
        logic       regDst;
        logic [1:0] aluOp;
    } ctrlWord_t;

    localparam ctrlWord_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/pipeline_hazard_controller_forward.sv
// ALU operand forwarding selects for the EX stage; purely combinational.
// Zero latency, no backpressure: EX/MEM result wins over MEM/WB, $zero never forwards.
module hazard_forward_unit
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] exRs,
    input  logic [REG_ADDR_W-1:0] exRt,
    input  logic                  memRegWrite,
    input  logic [REG_ADDR_W-1:0] memWriteReg,
    input  logic                  wbRegWrite,
    input  logic [REG_ADDR_W-1:0] wbWriteReg,
    output logic [1:0]            forwardA,
    output logic [1:0]            forwardB
);

    function automatic logic [1:0] fwdSel(input logic [REG_ADDR_W-1:0] src);
        if (memRegWrite && (memWriteReg != '0) && (memWriteReg == src))
            return FWD_MEM;
        else if (wbRegWrite && (wbWriteReg != '0) && (wbWriteReg == src))
            return FWD_WB;
        else
            return FWD_REG;
    endfunction

    always_comb begin
        forwardA = fwdSel(exRs);
        forwardB = fwdSel(exRt);
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline sequencing: post-reset drain, load-use stalls, branch squash, dmem wait/timeout.
// Control outputs are combinational from state and inputs; holds the pipe while dmem is not ready.
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int CNT_W       = 16,
    parameter int FILL_CYCLES = 4,
    parameter int TIMEOUT     = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rs,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_write_reg,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_write_reg,
    input  logic                  branch_taken,
    input  logic                  dmem_req,
    input  logic                  dmem_ready,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  exmem_flush,
    output logic                  pipe_hold,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count,
    output logic                  mem_timeout,
    output logic [1:0]            state
);

    localparam int FILL_W = $clog2(FILL_CYCLES + 1);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    logic [1:0]        nextState;
    logic [FILL_W-1:0] fillCnt, fillNext;
    logic [WAIT_W-1:0] waitCnt, waitNext;
    logic              loadUse, memStall, advance;
    logic              stallInc, flushInc, timeoutSet;

    assign loadUse  = ex_mem_read && (ex_rt != '0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    assign memStall = dmem_req && !dmem_ready;

    always_comb begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        pipe_hold   = 1'b0;
        nextState   = state;
        fillNext    = fillCnt;
        waitNext    = waitCnt;
        stallInc    = 1'b0;
        flushInc    = 1'b0;
        timeoutSet  = 1'b0;
        advance     = 1'b0;

        case (state)
            INIT: begin
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
                if (fillCnt == FILL_W'(FILL_CYCLES - 1)) begin
                    nextState = RUN;
                    fillNext  = '0;
                end else begin
                    fillNext = fillCnt + FILL_W'(1);
                end
            end
            RUN: begin
                if (memStall) begin
                    pipe_hold = 1'b1;
                    stallInc  = 1'b1;
                    nextState = MEM_WAIT;
                    // The RUN cycle that detects the wait is the first held cycle.
                    waitNext  = WAIT_W'(1);
                end else begin
                    advance = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    advance   = 1'b1;
                    nextState = RUN;
                    waitNext  = '0;
                end else begin
                    pipe_hold = 1'b1;
                    stallInc  = 1'b1;
                    if (waitCnt >= WAIT_W'(TIMEOUT - 1)) begin
                        timeoutSet = 1'b1;
                        nextState  = RUN;
                        waitNext   = '0;
                    end else begin
                        waitNext = waitCnt + WAIT_W'(1);
                    end
                end
            end
            default: begin
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
                nextState   = INIT;
                fillNext    = '0;
                waitNext    = '0;
            end
        endcase

        // Branch outranks load-use: the dependent instruction is squashed anyway.
        if (advance) begin
            if (branch_taken) begin
                pc_write    = 1'b1;
                ifid_write  = 1'b1;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
                flushInc    = 1'b1;
            end else if (loadUse) begin
                idex_flush = 1'b1;
                stallInc   = 1'b1;
            end else begin
                pc_write   = 1'b1;
                ifid_write = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= INIT;
            fillCnt     <= '0;
            waitCnt     <= '0;
            stall_count <= '0;
            flush_count <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state   <= nextState;
            fillCnt <= fillNext;
            waitCnt <= waitNext;
            if (stallInc && (stall_count != {CNT_W{1'b1}}))
                stall_count <= stall_count + CNT_W'(1);
            if (flushInc && (flush_count != {CNT_W{1'b1}}))
                flush_count <= flush_count + CNT_W'(1);
            if (timeoutSet)
                mem_timeout <= 1'b1;
        end
    end

    hazard_forward_unit #(
        .REG_ADDR_W(REG_ADDR_W)
    ) u_forward (
        .exRs       (ex_rs),
        .exRt       (ex_rt),
        .memRegWrite(mem_reg_write),
        .memWriteReg(mem_write_reg),
        .wbRegWrite (wb_reg_write),
        .wbWriteReg (wb_write_reg),
        .forwardA   (forward_a),
        .forwardB   (forward_b)
    );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed-vector bench for pipeline_hazard_controller with hand-computed expectations.
module tb_pipeline_hazard_controller;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, mem_write_reg, wb_write_reg;
    logic        id_uses_rt, ex_mem_read, mem_reg_write, wb_reg_write;
    logic        branch_taken, dmem_req, dmem_ready;
    logic        pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_hold;
    logic [1:0]  forward_a, forward_b, state;
    logic [15:0] stall_count, flush_count;
    logic        mem_timeout;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    pipeline_hazard_controller #(
        .REG_ADDR_W(5), .CNT_W(16), .FILL_CYCLES(4), .TIMEOUT(8)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .mem_reg_write(mem_reg_write), .mem_write_reg(mem_write_reg),
        .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
        .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .exmem_flush(exmem_flush), .pipe_hold(pipe_hold),
        .forward_a(forward_a), .forward_b(forward_b),
        .stall_count(stall_count), .flush_count(flush_count),
        .mem_timeout(mem_timeout), .state(state)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clearInputs();
        id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
        ex_mem_read = 1'b0; ex_rs = '0; ex_rt = '0;
        mem_reg_write = 1'b0; mem_write_reg = '0;
        wb_reg_write = 1'b0; wb_write_reg = '0;
        branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic fillAfterRelease();
        @(negedge clock);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);
    endtask

    initial begin
        clearInputs();
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_state", state, 2'd0);
        chk("rst_pc_write", pc_write, 1'b0);
        chk("rst_ifid_write", ifid_write, 1'b0);
        chk("rst_flushes", {ifid_flush, idex_flush, exmem_flush}, 3'b111);
        chk("rst_hold", pipe_hold, 1'b0);
        chk("rst_counts", {stall_count, flush_count}, 32'h0);
        chk("rst_timeout", mem_timeout, 1'b0);

        // Drain: hazards present but ignored for four edges.
        reset_n = 1'b1;
        ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; dmem_req = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            #1;
            chk($sformatf("fill%0d_state", k), state, 2'd0);
            chk($sformatf("fill%0d_pc", k), pc_write, 1'b0);
            chk($sformatf("fill%0d_flush", k), {ifid_flush, idex_flush, exmem_flush}, 3'b111);
            chk($sformatf("fill%0d_hold", k), pipe_hold, 1'b0);
            @(negedge clock);
        end
        clearInputs();
        #1;
        chk("run_state", state, 2'd1);
        chk("run_pc", {pc_write, ifid_write}, 2'b11);
        chk("run_flush", {ifid_flush, idex_flush, exmem_flush}, 3'b000);
        chk("fill_counts", {stall_count, flush_count}, 32'h0);

        // Load-use on rs
        @(negedge clock);
        ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        #1;
        chk("lu_pc", {pc_write, ifid_write}, 2'b00);
        chk("lu_flush", {ifid_flush, idex_flush, exmem_flush}, 3'b010);
        @(negedge clock);
        clearInputs();
        #1;
        chk("lu_stall_cnt", stall_count, 16'd1);
        chk("lu_clear_pc", pc_write, 1'b1);

        // Load into $zero never stalls
        ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        #1;
        chk("lu_zero_pc", pc_write, 1'b1);
        chk("lu_zero_flush", idex_flush, 1'b0);
        @(negedge clock);
        #1;
        chk("lu_zero_cnt", stall_count, 16'd1);

        // rt dependency only counts when the instruction reads rt
        ex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd3; id_uses_rt = 1'b0;
        #1;
        chk("lu_rt_unused", pc_write, 1'b1);
        id_uses_rt = 1'b1;
        #1;
        chk("lu_rt_used", {pc_write, idex_flush}, 2'b01);
        @(negedge clock);
        clearInputs();
        #1;
        chk("lu_rt_cnt", stall_count, 16'd2);

        // Forwarding
        ex_rs = 5'd8; mem_reg_write = 1'b1; mem_write_reg = 5'd8;
        wb_reg_write = 1'b1; wb_write_reg = 5'd8;
        #1;
        chk("fwd_a_mem", forward_a, 2'b10);
        chk("fwd_b_none", forward_b, 2'b00);
        mem_reg_write = 1'b0;
        #1;
        chk("fwd_a_wb", forward_a, 2'b01);
        mem_write_reg = 5'd0; ex_rs = 5'd0; wb_write_reg = 5'd0;
        #1;
        chk("fwd_a_zero", forward_a, 2'b00);
        ex_rt = 5'd9; mem_reg_write = 1'b1; mem_write_reg = 5'd9;
        wb_write_reg = 5'd9;
        #1;
        chk("fwd_b_mem", forward_b, 2'b10);
        mem_write_reg = 5'd4;
        #1;
        chk("fwd_b_wb", forward_b, 2'b01);
        clearInputs();

        // Branch taken with a simultaneous load-use hazard
        @(negedge clock);
        ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; branch_taken = 1'b1;
        #1;
        chk("br_flush", {ifid_flush, idex_flush, exmem_flush}, 3'b111);
        chk("br_pc", {pc_write, ifid_write}, 2'b11);
        @(negedge clock);
        clearInputs();
        #1;
        chk("br_flush_cnt", flush_count, 16'd1);
        chk("br_stall_cnt", stall_count, 16'd2);

        // Memory wait: three held cycles then ready
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("mw%0d_hold", i), {pipe_hold, pc_write, ifid_write}, 3'b100);
            @(negedge clock);
        end
        dmem_ready = 1'b1; branch_taken = 1'b0;
        #1;
        chk("mw_ready_state", state, 2'd2);
        chk("mw_ready_hold", {pipe_hold, pc_write}, 2'b01);
        @(negedge clock);
        clearInputs();
        #1;
        chk("mw_back_run", state, 2'd1);
        chk("mw_stall_cnt", stall_count, 16'd5);

        // Timeout: ready never arrives; branch held meanwhile is not acted on
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("to%0d_hold", i), pipe_hold, 1'b1);
            if (i == 7) chk("to_not_yet", mem_timeout, 1'b0);
            if (i == 3) branch_taken = 1'b1;
            if (i == 4) chk("to_br_ignored", exmem_flush, 1'b0);
            @(negedge clock);
        end
        clearInputs();
        #1;
        chk("to_flag", mem_timeout, 1'b1);
        chk("to_state", state, 2'd1);
        chk("to_stall_cnt", stall_count, 16'd13);
        chk("to_flush_cnt", flush_count, 16'd1);
        chk("to_hold_off", pipe_hold, 1'b0);

        // Asynchronous reset in the middle of a wait
        @(negedge clock);
        dmem_req = 1'b1;
        @(negedge clock);
        #1;
        chk("rmw_in_wait", state, 2'd2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rmw_state", state, 2'd0);
        chk("rmw_counts", {stall_count, flush_count}, 32'h0);
        chk("rmw_timeout", mem_timeout, 1'b0);
        chk("rmw_outputs", {pc_write, ifid_write, pipe_hold, exmem_flush}, 4'b0001);
        clearInputs();

        // Stall counter saturation under a persistent load-use hazard
        fillAfterRelease();
        ex_mem_read = 1'b1; ex_rt = 5'd6; id_rs = 5'd6;
        repeat (65540) @(negedge clock);
        #1;
        chk("sat_stall_cnt", stall_count, 16'hFFFF);
        clearInputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
